instr_loader: RTL and testbench

Program loader sitting directly upstream of the instruction-fetch stage. It receives the program as a byte stream from the UART receiver, writes each byte into instruction memory through the fetch stage's write port, and detects the HALT word that ends the program. It holds the PC in reset and disabled while loading, then reports completion to the debug unit.

---
 rtl/loader_pkg.sv | 16 +
 rtl/halt_detector.sv | 35 +++
 rtl/instr_loader.sv | 157 +++++++++++++++
 tb/tb_instr_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2
`ifdef LOADER_CHECKSUM_EN
        , CHECK = 2'd3
`endif
    } state_t;

    localparam logic [31:0] HALT_INSTR      = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_INSTR = 4;

endpackage

// File: rtl/halt_detector.sv
// rtl/halt_detector.sv - byte shift register and aligned HALT word comparison
module halt_detector
    import loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BYTE  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            shift,
    input  logic            word_end,
    input  logic [BYTE-1:0] data,
    output logic            hit
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_next;

    // The incoming byte becomes the LSB, so the first byte of a word ends up as its MSB.
    assign word_next = {word_q[WIDTH-BYTE-1:0], data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clear) begin
            word_q <= '0;
        end else if (shift) begin
            word_q <= word_next;
        end
    end

    assign hit = shift && word_end && (word_next == WIDTH'(HALT_INSTR));

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART byte-stream program loader; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module instr_loader
    import loader_pkg::*;
#(
    parameter int INSTMEM_SIZE = 8,
    parameter int MEM_SIZE     = 8,
    parameter int INST_SIZE    = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_load_start,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_write_en,
    output logic                    o_instrmem_en,
    output logic [INSTMEM_SIZE-1:0] o_write_addr,
    output logic [MEM_SIZE-1:0]     o_write_data,
    output logic                    o_pc_reset,
    output logic                    o_pc_en,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [INSTMEM_SIZE:0]   o_byte_count
);

    state_t                  state_q;
    state_t                  state_d;
    logic [INSTMEM_SIZE-1:0] addr_q;
    logic                    wr;
    logic                    start_clr;
    logic                    set_error;
    logic                    hit;
    logic                    active_d;
    logic                    idle_hold;

    halt_detector #(
        .WIDTH (INST_SIZE),
        .BYTE  (8)
    ) u_halt_detector (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .clear    (start_clr),
        .shift    (wr),
        .word_end (addr_q[1:0] == 2'(BYTES_PER_INSTR - 1)),
        .data     (i_rx_data),
        .hit      (hit)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            xor_q <= '0;
        end else if (start_clr) begin
            xor_q <= '0;
        end else if (wr) begin
            xor_q <= xor_q ^ i_rx_data;
        end
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr        = 1'b0;
        start_clr = 1'b0;
        set_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_load_start) begin
                    start_clr = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (i_rx_valid) begin
                    wr = 1'b1;
                    if (hit) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if (addr_q == '1) begin
                        // Last byte of memory without HALT: stop rather than wrap to address 0.
                        set_error = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (i_rx_valid) begin
                    set_error = (i_rx_data != xor_q);
                    state_d   = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    assign active_d = (state_d == LOAD) || (state_d == CHECK);
`else
    assign active_d = (state_d == LOAD);
`endif

    // The PC is released only once the DONE cycle has passed and no new load is starting.
    assign idle_hold = (state_q == IDLE) && (state_d == IDLE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr_q        <= '0;
            o_write_en    <= 1'b0;
            o_instrmem_en <= 1'b0;
            o_write_addr  <= '0;
            o_write_data  <= '0;
            o_pc_reset    <= 1'b1;
            o_pc_en       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_byte_count  <= '0;
        end else begin
            o_write_en    <= wr;
            o_instrmem_en <= active_d || wr;
            o_busy        <= active_d;
            o_done        <= (state_q == DONE);
            o_pc_reset    <= !idle_hold;
            o_pc_en       <= idle_hold;
            if (wr) begin
                o_write_addr <= addr_q;
                o_write_data <= i_rx_data;
                addr_q       <= addr_q + 1'b1;
                o_byte_count <= o_byte_count + 1'b1;
            end
            if (start_clr) begin
                addr_q       <= '0;
                o_byte_count <= '0;
                o_error      <= 1'b0;
            end else if (set_error) begin
                o_error      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       write_en;
    logic       instrmem_en;
    logic [7:0] write_addr;
    logic [7:0] write_data;
    logic       pc_reset;
    logic       pc_en;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] byte_count;

    int vecs  = 0;
    int fails = 0;

    logic [7:0] mem   [256];
    int         wr_at [256];
    int         wr_total;

    instr_loader #(
        .INSTMEM_SIZE (8),
        .MEM_SIZE     (8),
        .INST_SIZE    (32)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_load_start  (load_start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_write_en    (write_en),
        .o_instrmem_en (instrmem_en),
        .o_write_addr  (write_addr),
        .o_write_data  (write_data),
        .o_pc_reset    (pc_reset),
        .o_pc_en       (pc_en),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .o_byte_count  (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en) begin
            mem[write_addr]   = write_data;
            wr_at[write_addr] = wr_at[write_addr] + 1;
            wr_total          = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            wr_at[i] = 0;
        end
        wr_total = 0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_write_en"},    32'(write_en),    32'd0);
        check({tag, "_instrmem_en"}, 32'(instrmem_en), 32'd0);
        check({tag, "_write_addr"},  32'(write_addr),  32'd0);
        check({tag, "_write_data"},  32'(write_data),  32'd0);
        check({tag, "_pc_reset"},    32'(pc_reset),    32'd1);
        check({tag, "_pc_en"},       32'(pc_en),       32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_error"},       32'(error),       32'd0);
        check({tag, "_byte_count"},  32'(byte_count),  32'd0);
    endtask

    // Called right after the HALT word's last byte has been sampled.
    task automatic finish_load(input string tag, input logic [8:0] cnt, input logic err,
                               input logic [7:0] cks);
        check({tag, "_last_we"}, 32'(write_en), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_check_busy"}, 32'(busy), 32'd1);
        send(cks);
        check({tag, "_cks_not_written"}, 32'(write_en), 32'd0);
`else
        check({tag, "_cks_unused"}, 32'(cks), 32'(cks ^ 8'h00));
`endif
        check({tag, "_done_lag"}, 32'(done), 32'd0);
        step();
        check({tag, "_done"},     32'(done),       32'd1);
        check({tag, "_pc_hold"},  32'(pc_reset),   32'd1);
        check({tag, "_count"},    32'(byte_count), 32'(cnt));
        check({tag, "_error"},    32'(error),      32'(err));
        step();
        check({tag, "_done_end"}, 32'(done),     32'd0);
        check({tag, "_pc_rel"},   32'(pc_reset), 32'd0);
        check({tag, "_pc_en"},    32'(pc_en),    32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        clear_mon();
        repeat (3) step();
        check_reset_vals("rst");

        rst_n = 1'b1;
        step();
        check("idle_pc_en",    32'(pc_en),    32'd1);
        check("idle_pc_reset", 32'(pc_reset), 32'd0);
        check("idle_busy",     32'(busy),     32'd0);

        // Straight 2-instruction program ending in HALT
        start();
        check("start_busy",     32'(busy),       32'd1);
        check("start_pc_reset", 32'(pc_reset),   32'd1);
        check("start_pc_en",    32'(pc_en),      32'd0);
        check("start_count",    32'(byte_count), 32'd0);
        send(8'h00); send(8'h00); send(8'h00); send(8'h20);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        check("a_last_addr", 32'(write_addr), 32'd7);
        check("a_last_data", 32'(write_data), 32'hFF);
        finish_load("a", 9'd8, 1'b0, 8'h20);
        check("a_word0",  {mem[0], mem[1], mem[2], mem[3]}, 32'h0000_0020);
        check("a_word1",  {mem[4], mem[5], mem[6], mem[7]}, 32'hFFFF_FFFF);
        check("a_writes", 32'(wr_total), 32'd8);

        // Misaligned FF run must not be taken as HALT
        clear_mon();
        start();
        send(8'hFF); send(8'hFF); send(8'h00); send(8'hFF);
        check("b_word0_busy", 32'(busy), 32'd1);
        send(8'hFF); send(8'hFF);
        check("b_mis5_busy", 32'(busy), 32'd1);
        send(8'hFF);
        check("b_mis6_busy", 32'(busy), 32'd1);
        send(8'hFF);
        check("b_last_addr", 32'(write_addr), 32'd7);
        finish_load("b", 9'd8, 1'b0, 8'hFF);
        check("b_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'hFFFF_00FF);

        // Fill the whole memory without HALT
        clear_mon();
        start();
        for (int i = 0; i < 256; i++) send(8'(i) & 8'h7F);
        check("c_last_we",   32'(write_en),   32'd1);
        check("c_last_addr", 32'(write_addr), 32'd255);
        check("c_last_data", 32'(write_data), 32'h7F);
        send(8'hAA);
        check("c_done",   32'(done),       32'd1);
        check("c_error",  32'(error),      32'd1);
        check("c_count",  32'(byte_count), 32'd256);
        check("c_no_we_done", 32'(write_en), 32'd0);
        send(8'h55);
        check("c_pc_en",  32'(pc_en),    32'd1);
        check("c_no_we_idle", 32'(write_en), 32'd0);
        step();
        check("c_writes", 32'(wr_total), 32'd256);
        check("c_addr0_once", 32'(wr_at[0]), 32'd1);
        check("c_mem0", 32'(mem[0]), 32'd0);
        check("c_error_sticky", 32'(error), 32'd1);

        // Back-to-back bytes with a stray load_start mid-load
        clear_mon();
        start();
        check("d_error_cleared", 32'(error), 32'd0);
        send(8'h11); send(8'h22);
        load_start = 1'b1;
        send(8'h33);
        load_start = 1'b0;
        send(8'h44);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        finish_load("d", 9'd8, 1'b0, 8'h44);
        check("d_writes",  32'(wr_total), 32'd8);
        check("d_addr2_once", 32'(wr_at[2]), 32'd1);
        check("d_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h1122_3344);

        // Asynchronous reset in the middle of a load
        start();
        send(8'h01); send(8'h02); send(8'h03);
        rx_data  = 8'h04;
        rx_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("e");
        rx_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("e_pc_en", 32'(pc_en), 32'd1);
        check("e_busy",  32'(busy),  32'd0);

`ifdef LOADER_CHECKSUM_EN
        clear_mon();
        start();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        finish_load("f_good", 9'd8, 1'b0, 8'h04);
        check("f_good_writes", 32'(wr_total), 32'd8);
        clear_mon();
        start();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        finish_load("f_bad", 9'd8, 1'b1, 8'h05);
        check("f_bad_writes", 32'(wr_total), 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
